// File: rtl/cond_sum_adder_scheduler.sv
// cond_sum_adder_scheduler
//
// Round-robin arbiter and byte-serial sequencer that shares one registered
// 8-bit conditional-sum adder between two requesters. Each accepted request is
// a W-bit addition (W = 8*NBYTES). It is issued one byte per cycle to the
// external adder, and the adder's registered carry feeds the next byte.
//
// Ports
//   clk                  clock shared with the external adder
//   rst                  asynchronous reset, active low
//   req0_valid/ready     requester 0 handshake (ready is combinational)
//   req0_a/b/cin         requester 0 operands and carry-in
//   req1_valid/ready     requester 1 handshake (ready is combinational)
//   req1_a/b/cin         requester 1 operands and carry-in
//   add_a/add_b/add_cin  byte and carry presented to the adder
//   add_sum/add_cout     adder registered result (1-cycle latency)
//   res_valid/ready      result handshake
//   res_id               requester that owns the result
//   res_sum/res_cout     W-bit sum and final carry-out
//   busy                 operation in flight (RUN or RESP)
module cond_sum_adder_scheduler #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_cin,
  output logic [7:0]          add_a,
  output logic [7:0]          add_b,
  output logic                add_cin,
  input  logic [7:0]          add_sum,
  input  logic                add_cout,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_id,
  output logic [8*NBYTES-1:0] res_sum,
  output logic                res_cout,
  output logic                busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES + 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [IW-1:0] idx_r;
  logic          last_r;
  logic [W-1:0]  op_a_r;
  logic [W-1:0]  op_b_r;
  logic          cin_r;
  logic          res_valid_r;
  logic          res_id_r;
  logic [W-1:0]  res_sum_r;
  logic          res_cout_r;
  logic          busy_r;

  logic          grant_s;
  logic          ready0_s;
  logic          ready1_s;
  logic          hs_s;
  logic [W-1:0]  sel_a_s;
  logic [W-1:0]  sel_b_s;
  logic          sel_cin_s;
  logic [7:0]    add_a_s;
  logic [7:0]    add_b_s;
  logic          add_cin_s;
  logic [W+7:0]  cat_s;

  // Arbitration: a lone requester wins; under contention the one not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    // Gating with rst keeps both readies low while reset is asserted.
    ready0_s = rst && (state_r == IDLE) && req0_valid && !grant_s;
    ready1_s = rst && (state_r == IDLE) && req1_valid && grant_s;
    hs_s     = ready0_s || ready1_s;
    if (grant_s) begin
      sel_a_s   = req1_a;
      sel_b_s   = req1_b;
      sel_cin_s = req1_cin;
    end else begin
      sel_a_s   = req0_a;
      sel_b_s   = req0_b;
      sel_cin_s = req0_cin;
    end
  end

  // Adder drive: the operand registers shift down one byte per RUN cycle, so byte k sits at [7:0].
  always_comb begin
    add_a_s   = 8'd0;
    add_b_s   = 8'd0;
    add_cin_s = 1'b0;
    if ((state_r == RUN) && (idx_r < IDX_LAST)) begin
      add_a_s = op_a_r[7:0];
      add_b_s = op_b_r[7:0];
      // Byte 0 uses the request carry; later bytes chain the adder's registered carry.
      if (idx_r == IDX_ZERO) begin
        add_cin_s = cin_r;
      end else begin
        add_cin_s = add_cout;
      end
    end else begin
      add_a_s   = 8'd0;
      add_b_s   = 8'd0;
      add_cin_s = 1'b0;
    end
  end

  // Result bytes enter from the top, so after NBYTES captures byte 0 sits at [7:0].
  assign cat_s = {add_sum, res_sum_r};

  // Control FSM together with operand, result and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      idx_r       <= IDX_ZERO;
      last_r      <= 1'b1;
      op_a_r      <= {W{1'b0}};
      op_b_r      <= {W{1'b0}};
      cin_r       <= 1'b0;
      res_valid_r <= 1'b0;
      res_id_r    <= 1'b0;
      res_sum_r   <= {W{1'b0}};
      res_cout_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            op_a_r   <= sel_a_s;
            op_b_r   <= sel_b_s;
            cin_r    <= sel_cin_s;
            res_id_r <= grant_s;
            last_r   <= grant_s;
            idx_r    <= IDX_ZERO;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          idx_r  <= idx_r + IW'(1);
          op_a_r <= op_a_r >> 4'd8;
          op_b_r <= op_b_r >> 4'd8;
          // The adder result for byte k-1 appears one cycle after it was issued.
          if (idx_r != IDX_ZERO) begin
            res_sum_r <= cat_s[W+7:8];
          end
          if (idx_r == IDX_LAST) begin
            res_cout_r  <= add_cout;
            res_valid_r <= 1'b1;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= IDX_ZERO;
          res_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;
  assign add_a      = add_a_s;
  assign add_b      = add_b_s;
  assign add_cin    = add_cin_s;
  assign res_valid  = res_valid_r;
  assign res_id     = res_id_r;
  assign res_sum    = res_sum_r;
  assign res_cout   = res_cout_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cond_sum_adder_scheduler.sv
// Testbench for cond_sum_adder_scheduler (NBYTES = 4). The shared adder is
// modelled here as a registered 8-bit adder with 1-cycle latency. Inputs are
// driven on the falling edge, and outputs are sampled 1 ns later.
module tb_cond_sum_adder_scheduler;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [7:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         res_valid, res_ready, res_id, res_cout, busy;
  logic [W-1:0] res_sum;

  int checks   = 0;
  int failures = 0;

  cond_sum_adder_scheduler #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_sum(res_sum),
    .res_cout(res_cout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared adder: registered sum/carry, held in reset while rst is low.
  always_ff @(posedge clk) begin
    if (!rst) {add_cout, add_sum} <= 9'd0;
    else      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One request from requester id. If contend is set, the other requester is also valid in the handshake cycle.
  task automatic do_op(input string tag, input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic contend, output logic [3:0] cin_seen);
    logic [W:0] exp;
    int cyc;
    logic got;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    cin_seen = 4'd0;
    @(negedge clk);
    res_ready = 1'b1;
    req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
    req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
    if (id == 1'b0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req1_valid = contend;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req0_valid = contend;
    end
    #1;
    check_val({tag, "_ready"}, id ? req1_ready : req0_ready, 64'd1);
    check_val({tag, "_other_ready"}, id ? req0_ready : req1_ready, 64'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = $urandom; req1_a = $urandom;
      cyc++;
      #1;
      if (cyc >= 1 && cyc <= 4) cin_seen[cyc-1] = add_cin;
      if (res_valid) begin
        got = 1'b1;
        check_val({tag, "_latency"}, 64'(cyc), 64'd6);
        check_val({tag, "_sum"}, res_sum, exp[W-1:0]);
        check_val({tag, "_cout"}, res_cout, exp[W]);
        check_val({tag, "_id"}, res_id, id);
      end
    end
    if (!got) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  typedef struct {
    logic       id;
    logic [W:0] val;
  } exp_t;

  initial begin
    logic [3:0] cin_seen;
    logic [W:0] e0, e1, ebp;
    int n, cyc, done, hs_cycle;
    logic m_last, free, x0, x1, exp_rv;
    exp_t q[$];
    exp_t item;

    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check_val("rst_res_valid", res_valid, 64'd0);
    check_val("rst_busy", busy, 64'd0);
    check_val("rst_ready0", req0_ready, 64'd0);
    check_val("rst_add", {add_a, add_b, add_cin}, 64'd0);
    check_val("rst_res", {res_id, res_cout, res_sum}, 64'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    do_op("single", 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, cin_seen);
    do_op("ripple", 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, cin_seen);
    check_val("ripple_cin_chain", cin_seen, 64'hF);

    // Contention: both requesters valid continuously after reset.
    apply_reset();
    e0 = {1'b0, 32'h1234_5678} + {1'b0, 32'h9ABC_DEF0};
    e1 = {1'b0, 32'h8000_0000} + {1'b0, 32'h8000_0001} + 33'd1;
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 100) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h9ABC_DEF0; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 32'h8000_0000; req1_b = 32'h8000_0001; req1_cin = 1'b1;
      res_ready = 1'b1;
      cyc++;
      #1;
      check_val("cont_both_ready", req0_ready & req1_ready, 64'd0);
      if (res_valid) begin
        check_val("cont_id", res_id, 64'(n % 2));
        check_val("cont_sum", {res_cout, res_sum}, (n % 2) ? e1 : e0);
        n++;
      end
    end
    check_val("cont_count", 64'(n), 64'd4);

    // Backpressure: results held for 10 cycles while both requesters wait.
    apply_reset();
    ebp = {1'b0, 32'hDEAD_BEEF} + {1'b0, 32'h3000_0000} + 33'd1;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'hDEAD_BEEF; req0_b = 32'h3000_0000; req0_cin = 1'b1;
    res_ready = 1'b0;
    #1;
    check_val("bp_ready", req0_ready, 64'd1);
    cyc = 0;
    do begin
      @(negedge clk);
      req0_valid = 1'b0;
      cyc++;
      #1;
    end while (!res_valid && cyc < 20);
    check_val("bp_reached_resp", res_valid, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check_val("bp_valid", res_valid, 64'd1);
      check_val("bp_result", {res_id, res_cout, res_sum}, {1'b0, ebp});
      check_val("bp_readies", {req0_ready, req1_ready}, 64'd0);
      check_val("bp_busy", busy, 64'd1);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    #1;
    check_val("bp_xfer_valid", res_valid, 64'd1);
    @(negedge clk);
    #1;
    check_val("bp_after_valid", res_valid, 64'd0);
    check_val("bp_after_busy", busy, 64'd0);
    @(negedge clk);
    #1;
    check_val("bp_single_xfer", res_valid, 64'd0);

    // Reset in cycle 3 of an operation, then req0 must win contention.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h0F0F_0F0F; req1_b = 32'hF0F0_F0F1; req1_cin = 1'b0;
    #1;
    check_val("mr_ready1", req1_ready, 64'd1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1;
    #1;
    check_val("mr_res_valid", res_valid, 64'd0);
    check_val("mr_busy", busy, 64'd0);
    check_val("mr_readies", {req0_ready, req1_ready}, 64'd0);
    check_val("mr_add", {add_a, add_b, add_cin}, 64'd0);
    check_val("mr_res", {res_id, res_cout, res_sum}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b0;
    #1;
    check_val("mr_no_resp", res_valid, 64'd0);
    do_op("postrst", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, cin_seen);

    // Random traffic against a transaction-level scoreboard.
    apply_reset();
    m_last = 1'b1;
    done = 0;
    cyc = 0;
    hs_cycle = 0;
    while (done < 1000 && cyc < 40000) begin
      @(negedge clk);
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      cyc++;
      #1;
      free = (q.size() == 0);
      x0 = 1'b0; x1 = 1'b0;
      if (free) begin
        if (req0_valid && req1_valid) begin
          x0 = m_last; x1 = ~m_last;
        end else begin
          x0 = req0_valid; x1 = req1_valid;
        end
      end
      exp_rv = !free && ((cyc - hs_cycle) >= NB + 2);
      check_val("rnd_readies", {req0_ready, req1_ready}, {x0, x1});
      check_val("rnd_busy", busy, !free);
      check_val("rnd_res_valid", res_valid, exp_rv);
      if (res_valid && res_ready && !free) begin
        item = q.pop_front();
        check_val("rnd_sum", {res_cout, res_sum}, item.val);
        check_val("rnd_id", res_id, item.id);
        done++;
      end
      if (x0) begin
        item.id = 1'b0;
        item.val = {1'b0, req0_a} + {1'b0, req0_b} + {{W{1'b0}}, req0_cin};
        q.push_back(item);
        m_last = 1'b0;
        hs_cycle = cyc;
      end else if (x1) begin
        item.id = 1'b1;
        item.val = {1'b0, req1_a} + {1'b0, req1_b} + {{W{1'b0}}, req1_cin};
        q.push_back(item);
        m_last = 1'b1;
        hs_cycle = cyc;
      end
    end
    check_val("rnd_done", 64'(done), 64'd1000);
    check_val("rnd_leftover", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
